// File: rtl/ff_init_sequencer_pkg.sv
// Shared types and helpers for the flop-bank preset/clear sequencer.
// Holds the FSM state encoding, the request kind codes and the counter sizing rule.
package ff_ctrl_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        ASSERT  = 2'd1,
        RECOVER = 2'd2,
        RUN     = 2'd3
    } state_e;

    localparam logic [1:0] KIND_NOP  = 2'b00;
    localparam logic [1:0] KIND_CLR  = 2'b01;
    localparam logic [1:0] KIND_SET  = 2'b10;
    localparam logic [1:0] KIND_BOTH = 2'b11;

    // The counter only ever holds values up to max(...)-1, so clog2 of the max is enough.
    function automatic int cnt_width(input int pulse_cycles, input int recovery_cycles);
        int m;
        m = (pulse_cycles > recovery_cycles) ? pulse_cycles : recovery_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ff_init_sequencer_preset_sync.sv
// Reset-release synchronizer: asserts asynchronously, releases after STAGES rising edges.
module preset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic preset,
    output logic sync_o
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/ff_init_sequencer.sv
// Drives the active-low preset/clear pins and capture enable of the async flop bank,
// enforcing minimum pulse width and recovery time on power-up and on request.
module ff_init_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int PULSE_CYCLES    = 2,
    parameter int RECOVERY_CYCLES = 1
) (
    input  logic       clk,
    input  logic       preset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_kind,
    input  logic       err_clr,
    output logic       preset_n_o,
    output logic       clear_n_o,
    output logic       cap_en,
    output logic       done,
    output logic       err
);
    import ff_ctrl_pkg::*;

    localparam int CNT_W = cnt_width(PULSE_CYCLES, RECOVERY_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVERY_CYCLES - 1);
    // Clear has been low since reset, so the SYNC exit cycle already counts toward the pulse.
    localparam logic [CNT_W-1:0] SYNC_LOAD    = CNT_W'((PULSE_CYCLES >= 2) ? PULSE_CYCLES - 2 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             preset_n_q, preset_n_d;
    logic             clear_n_q, clear_n_d;
    logic             cap_en_q, cap_en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             nop_pend_q, nop_pend_d;
    logic             sync_ok;
    logic             accept;

    preset_sync #(.STAGES(SYNC_STAGES)) u_preset_sync (
        .clk    (clk),
        .preset (preset),
        .sync_o (sync_ok)
    );

    assign accept = req_valid && (state_q == RUN);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        preset_n_d = preset_n_q;
        clear_n_d  = clear_n_q;
        cap_en_d   = cap_en_q;
        done_d     = nop_pend_q;
        nop_pend_d = 1'b0;
        err_d      = err_q;

        if (accept && (req_kind == KIND_BOTH)) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            SYNC: begin
                if (sync_ok) begin
                    if (PULSE_CYCLES == 1) begin
                        clear_n_d = 1'b1;
                        cnt_d     = RECOVER_LOAD;
                        state_d   = RECOVER;
                    end else begin
                        cnt_d   = SYNC_LOAD;
                        state_d = ASSERT;
                    end
                end
            end
            ASSERT: begin
                if (cnt_q == '0) begin
                    preset_n_d = 1'b1;
                    clear_n_d  = 1'b1;
                    cnt_d      = RECOVER_LOAD;
                    state_d    = RECOVER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RECOVER: begin
                if (cnt_q == '0) begin
                    cap_en_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    if (req_kind == KIND_NOP) begin
                        nop_pend_d = 1'b1;
                    end else begin
                        // Kind 11 falls into the clear branch so both pins are never low together.
                        if (req_kind[0]) begin
                            clear_n_d = 1'b0;
                        end else begin
                            preset_n_d = 1'b0;
                        end
                        cap_en_d = 1'b0;
                        cnt_d    = PULSE_LOAD;
                        state_d  = ASSERT;
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            state_q    <= SYNC;
            cnt_q      <= '0;
            preset_n_q <= 1'b1;
            clear_n_q  <= 1'b0;
            cap_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            nop_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            preset_n_q <= preset_n_d;
            clear_n_q  <= clear_n_d;
            cap_en_q   <= cap_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
            nop_pend_q <= nop_pend_d;
        end
    end

    assign req_ready  = (state_q == RUN);
    assign preset_n_o = preset_n_q;
    assign clear_n_o  = clear_n_q;
    assign cap_en     = cap_en_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
